// File: rtl/pixel_bus_arbiter.sv
// Round-robin arbiter that lets several drawing engines share the single
// pixel-plot port of the VGA adapter, one exclusive burst per grant.
module pixel_bus_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          IDX_W     = 2,
  parameter int          X_W       = 8,
  parameter int          Y_W       = 7,
  parameter int          C_W       = 3,
  parameter logic [15:0] MAX_BURST = 16'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ-1:0]     pix_last,
  input  logic [NUM_REQ*X_W-1:0] pix_x,
  input  logic [NUM_REQ*Y_W-1:0] pix_y,
  input  logic [NUM_REQ*C_W-1:0] pix_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     pix_ready,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  output logic [15:0]            burst_count
);

  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;
  state_t state;

  // owner doubles as the round-robin pointer: it always names the last winner.
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] next_idx;
  logic             found;

  always_comb begin
    cand     = owner;
    next_idx = owner;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(owner) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  logic        beat;
  logic        end_burst;
  logic [15:0] count_next;

  assign count_next = burst_count + 16'd1;
  assign beat       = (state == BURST) && pix_valid[owner];
  // A dropped request ends the burst even when the same cycle carries a beat.
  assign end_burst  = (beat && pix_last[owner]) || !req[owner] ||
                      ((MAX_BURST != 16'd0) && beat && (count_next == MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= IDX_W'(NUM_REQ - 1);
      burst_count <= 16'd0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
    end else begin
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= NUM_REQ'(1) << next_idx;
            owner       <= next_idx;
            burst_count <= 16'd0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            plot   <= 1'b1;
            x      <= pix_x[int'(owner)*X_W +: X_W];
            y      <= pix_y[int'(owner)*Y_W +: Y_W];
            colour <= pix_colour[int'(owner)*C_W +: C_W];
            if (burst_count != 16'hFFFF) burst_count <= count_next;
          end
          if (end_burst) begin
            grant <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pix_ready = grant;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pixel_bus_arbiter.sv
// Bench for pixel_bus_arbiter: two instances (unlimited and 4-beat bursts)
// share one stimulus stream and are compared every cycle against a reference model.
module tb_pixel_bus_arbiter;
  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req, pix_valid, pix_last;
  logic [N*XW-1:0] pix_x;
  logic [N*YW-1:0] pix_y;
  logic [N*CW-1:0] pix_colour;

  logic [N-1:0]  grant_o [2];
  logic [N-1:0]  ready_o [2];
  logic [XW-1:0] x_o     [2];
  logic [YW-1:0] y_o     [2];
  logic [CW-1:0] c_o     [2];
  logic          plot_o  [2];
  logic          busy_o  [2];
  logic [1:0]    owner_o [2];
  logic [15:0]   burst_o [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_plots  = 0;
  bit count_plots = 0;

  always #5 clk = ~clk;

  pixel_bus_arbiter #(.MAX_BURST(16'd0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .grant(grant_o[0]), .pix_ready(ready_o[0]), .x(x_o[0]), .y(y_o[0]), .colour(c_o[0]),
    .plot(plot_o[0]), .busy(busy_o[0]), .owner(owner_o[0]), .burst_count(burst_o[0])
  );

  pixel_bus_arbiter #(.MAX_BURST(16'd4)) dut1 (
    .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .grant(grant_o[1]), .pix_ready(ready_o[1]), .x(x_o[1]), .y(y_o[1]), .colour(c_o[1]),
    .plot(plot_o[1]), .busy(busy_o[1]), .owner(owner_o[1]), .burst_count(burst_o[1])
  );

  // Reference model: who holds the bus (-1 = nobody), whether the one-cycle
  // release gap is running, the last winner, and the last plotted pixel.
  int m_cur [2], m_last [2], m_cnt [2], m_x [2], m_y [2], m_c [2];
  bit m_rel [2], m_plot [2];

  task automatic model_reset(input int k);
    m_cur[k] = -1; m_rel[k] = 0; m_last[k] = N - 1; m_cnt[k] = 0;
    m_plot[k] = 0; m_x[k] = 0; m_y[k] = 0; m_c[k] = 0;
  endtask

  task automatic model_step(input int k, input int mb);
    bit acc, done;
    int i;
    if (reset) begin
      model_reset(k);
      return;
    end
    m_plot[k] = 0;
    if (m_rel[k]) begin
      m_rel[k] = 0;
    end else if (m_cur[k] < 0) begin
      for (int s = 1; s <= N; s++) begin
        i = (m_last[k] + s) % N;
        if (m_cur[k] < 0 && req[i]) begin
          m_cur[k] = i; m_last[k] = i; m_cnt[k] = 0;
        end
      end
    end else begin
      i = m_cur[k];
      acc = pix_valid[i];
      if (acc) begin
        m_plot[k] = 1;
        m_x[k] = int'((pix_x >> (i*XW)) & 32'hFF);
        m_y[k] = int'((pix_y >> (i*YW)) & 32'h7F);
        m_c[k] = int'((pix_colour >> (i*CW)) & 32'h7);
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
      done = (acc && pix_last[i]) || !req[i] || (mb != 0 && acc && m_cnt[k] == mb);
      if (done) begin
        m_cur[k] = -1; m_rel[k] = 1;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] eg;
    for (int k = 0; k < 2; k++) begin
      eg = (m_cur[k] >= 0) ? (32'd1 << m_cur[k]) : 32'd0;
      check_eq($sformatf("d%0d.grant", k), 32'(grant_o[k]), eg);
      check_eq($sformatf("d%0d.ready", k), 32'(ready_o[k]), eg);
      check_eq($sformatf("d%0d.plot", k), 32'(plot_o[k]), 32'(m_plot[k]));
      check_eq($sformatf("d%0d.x", k), 32'(x_o[k]), 32'(m_x[k]));
      check_eq($sformatf("d%0d.y", k), 32'(y_o[k]), 32'(m_y[k]));
      check_eq($sformatf("d%0d.colour", k), 32'(c_o[k]), 32'(m_c[k]));
      check_eq($sformatf("d%0d.busy", k), 32'(busy_o[k]), 32'(m_cur[k] >= 0 || m_rel[k]));
      check_eq($sformatf("d%0d.owner", k), 32'(owner_o[k]), 32'(m_last[k]));
      check_eq($sformatf("d%0d.burst_count", k), 32'(burst_o[k]), 32'(m_cnt[k]));
    end
    if (count_plots && plot_o[0] === 1'b1) n_plots++;
  endtask

  // One clock: check the state left by the previous edge, then apply new inputs
  // and advance the model across the coming edge.
  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] v,
                       input logic [N-1:0] l, input logic [N*XW-1:0] px,
                       input logic [N*YW-1:0] py, input logic [N*CW-1:0] pc);
    @(negedge clk);
    compare_all();
    reset = r; req = rq; pix_valid = v; pix_last = l;
    pix_x = px; pix_y = py; pix_colour = pc;
    model_step(0, 0);
    model_step(1, 4);
  endtask

  logic [N*XW-1:0] fx;
  logic [N*YW-1:0] fy;
  logic [N*CW-1:0] fc;
  logic [N-1:0]    rq_r;

  initial begin
    reset = 1'b1; req = '0; pix_valid = '0; pix_last = '0;
    pix_x = '0; pix_y = '0; pix_colour = '0;
    repeat (2) @(posedge clk);
    model_reset(0);
    model_reset(1);

    // Idle after reset.
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0, '0);
    repeat (10) cycle(1'b0, 4'b0000, 4'b1111, 4'b0000, '0, '0, '0);

    // Everybody requesting with one-beat bursts: client i plots (25i, 25i, i+2).
    for (int i = 0; i < N; i++) begin
      fx[i*XW +: XW] = XW'(25 * i);
      fy[i*YW +: YW] = YW'(25 * i);
      fc[i*CW +: CW] = CW'(i + 2);
    end
    repeat (24) cycle(1'b0, 4'b1111, 4'b1111, 4'b1111, fx, fy, fc);

    // Long stream from client 0 alone, valid on alternate cycles.
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, '0, '0, '0);
    cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, '0, '0, '0);
    count_plots = 1;
    for (int c = 1; c <= 38401; c++)
      cycle(1'b0, 4'b0001, (c % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000,
            N*XW'($urandom), N*YW'($urandom), N*CW'($urandom));
    cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, '0, '0, '0);
    cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, '0, '0, '0);
    count_plots = 0;
    check_eq("stream.plots", 32'(n_plots), 32'd19200);
    check_eq("stream.burst_count", 32'(burst_o[0]), 32'd19200);

    // Random traffic with occasional resets.
    rq_r = '0;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rq_r[i] = ~rq_r[i];
      cycle(($urandom_range(0, 249) == 0), rq_r, N'($urandom), N'($urandom) & N'($urandom),
            N*XW'($urandom), N*YW'($urandom), N*CW'($urandom));
    end
    repeat (4) cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
